// File: rtl/adc_sample_controller_pkg.sv
// Shared definitions for the serial ADC sample controller: FSM encoding,
// default timing constants and a small sizing helper.
package adc_sample_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } adc_state_e;

    localparam int DEF_DATA_W        = 16;
    localparam int DEF_CLK_DIV       = 4;
    localparam int DEF_CONV_WAIT     = 8;
    localparam int DEF_SAMPLE_PERIOD = 200;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_sample_controller_sclk_gen.sv
// Half-period divider for the ADC serial clock; also flags the clk edge on
// which sclk will go 0->1 so the top can sample sdo on that same edge.
module adc_sample_controller_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             terminal;

    assign terminal = (div_q == DIV_W'(CLK_DIV - 1));

    // Divider and sclk are parked at zero whenever the shift phase is inactive
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (terminal) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = en_i & terminal & ~sclk_q;

endmodule

// File: rtl/adc_sample_controller.sv
// Serial ADC front end: triggers conversions (manual or periodic), clocks one
// sample in MSB-first and presents it as a held word with a valid strobe.
module adc_sample_controller
    import adc_sample_controller_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int CONV_WAIT     = DEF_CONV_WAIT,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_en,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] adc_data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int SHIFT_CYC = 2 * DATA_W * CLK_DIV;
    localparam int CNT_MAX   = max3(CONV_WAIT, SHIFT_CYC, CLK_DIV);
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TMR_W     = $clog2(SAMPLE_PERIOD + 1);

    adc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              overrun_q, overrun_d;

    logic tick;
    logic trigger;
    logic sclk_en;
    logic sclk_rise;
    logic sclk;

    adc_sample_controller_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (sclk_en),
        .sclk_o (sclk),
        .rise_o (sclk_rise)
    );

    assign sclk_en = (state_q == ST_SHIFT);

    // Free-running only while auto_en is high; dropping it restarts the period
    always_comb begin
        tick = auto_en && (timer_q == TMR_W'(SAMPLE_PERIOD - 1));
        if (!auto_en || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign trigger = start | tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (trigger) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_q == CNT_W'(CONV_WAIT - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(SHIFT_CYC - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        adc_cs_n = !((state_q == ST_CONV) || (state_q == ST_SHIFT));
        busy     = (state_q != ST_IDLE);
    end

    // Any trigger seen outside IDLE is dropped but remembered until reset
    always_comb begin
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (trigger && (state_q != ST_IDLE));
        if (sclk_rise) begin
            shift_d = {shift_q[DATA_W-2:0], adc_sdo};
        end
        if (state_q == ST_DONE) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            timer_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
        end
    end

    assign adc_sclk   = sclk;
    assign adc_data   = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_sample_controller.sv
// Scoreboard bench for adc_sample_controller: expected samples and their
// valid cycle are queued at trigger time and retired when data_valid fires.
module tb_adc_sample_controller;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        adc_sdo = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [15:0] adc_data;
    logic        data_valid;
    logic        busy;
    logic        overrun;

    int          vectorsApplied = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          riseCount = 0;
    int          lowCount = 0;
    logic        prevValid = 1'b0;
    logic        prevSclk = 1'b0;
    logic        prevCs = 1'b1;
    logic [15:0] adcWord = 16'h0000;
    logic [15:0] adcShift = 16'h0000;
    exp_t        sbQueue[$];

    adc_sample_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .auto_en    (auto_en),
        .adc_sdo    (adc_sdo),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_data   (adc_data),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // ADC model, sclk/cs_n activity counters and scoreboard retirement
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            riseCount = 0;
            lowCount  = 0;
            prevValid = 1'b0;
            prevSclk  = 1'b0;
            prevCs    = 1'b1;
        end else begin
            if (data_valid) begin
                checkOutput("valid width", {31'd0, prevValid}, 0);
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected valid", {31'd0, data_valid}, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("data", {16'd0, adc_data}, {16'd0, e.data});
                    checkOutput("latency", cyc, e.cyc);
                    checkOutput("sclk rises", riseCount, 16);
                    checkOutput("cs_n low cycles", lowCount, 136);
                end
                riseCount = 0;
                lowCount  = 0;
            end
            if (adc_sclk && !prevSclk) riseCount++;
            if (!adc_cs_n) lowCount++;
            if (prevCs && !adc_cs_n) adcShift = adcWord;
            else if (prevSclk && !adc_sclk) adcShift = adcShift << 1;
            adc_sdo   = adcShift[15];
            prevValid = data_valid;
            prevSclk  = adc_sclk;
            prevCs    = adc_cs_n;
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        sbQueue.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [15:0] word, input bit expectResult);
        exp_t e;
        @(negedge clk);
        adcWord = word;
        start   = 1'b1;
        if (expectResult) begin
            e.data = word;
            e.cyc  = cyc + 1 + 137;
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput("busy after trigger", {31'd0, busy}, 1);
        checkOutput("cs_n after trigger", {31'd0, adc_cs_n}, 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput("idle timeout", {31'd0, busy}, 0);
    endtask

    initial begin
        int   e0;
        exp_t ex;

        // Reset values while held
        repeat (3) @(negedge clk);
        checkOutput("rst cs_n", {31'd0, adc_cs_n}, 1);
        checkOutput("rst sclk", {31'd0, adc_sclk}, 0);
        checkOutput("rst data", {16'd0, adc_data}, 0);
        checkOutput("rst valid", {31'd0, data_valid}, 0);
        checkOutput("rst busy", {31'd0, busy}, 0);
        checkOutput("rst overrun", {31'd0, overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual conversion, then a second start 20 cycles in
        applyStimulus(16'h3081, 1'b1);
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("overrun set", {31'd0, overrun}, 1);
        @(negedge clk);
        start = 1'b0;
        waitIdle(400);
        checkOutput("data after overrun", {16'd0, adc_data}, 32'h3081);
        checkOutput("overrun sticky", {31'd0, overrun}, 1);
        repeat (20) @(negedge clk);
        checkOutput("overrun still sticky", {31'd0, overrun}, 1);
        applyReset();
        checkOutput("overrun cleared", {31'd0, overrun}, 0);
        checkOutput("data cleared", {16'd0, adc_data}, 0);

        // Periodic conversions with sdo all ones
        @(negedge clk);
        adcWord = 16'hFFFF;
        auto_en = 1'b1;
        e0 = cyc;
        ex.data = 16'hFFFF;
        ex.cyc  = e0 + 200 + 137;
        sbQueue.push_back(ex);
        ex.cyc  = e0 + 400 + 137;
        sbQueue.push_back(ex);
        while (cyc < e0 + 545) @(negedge clk);
        auto_en = 1'b0;
        checkOutput("auto sb drained", sbQueue.size(), 0);
        checkOutput("auto overrun", {31'd0, overrun}, 0);
        checkOutput("auto busy", {31'd0, busy}, 0);

        // Reset in the middle of bit 7 aborts the conversion
        applyStimulus(16'h5A5A, 1'b0);
        for (int i = 0; i < 300 && riseCount < 8; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("reach bit7", riseCount, 8);
        rst_n = 1'b0;
        #1;
        checkOutput("abort cs_n", {31'd0, adc_cs_n}, 1);
        checkOutput("abort sclk", {31'd0, adc_sclk}, 0);
        checkOutput("abort busy", {31'd0, busy}, 0);
        checkOutput("abort valid", {31'd0, data_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("abort data", {16'd0, adc_data}, 0);
        applyStimulus(16'h0000, 1'b1);
        waitIdle(400);
        checkOutput("zero sample", {16'd0, adc_data}, 0);

        // Start coinciding with the first timer tick
        applyReset();
        @(negedge clk);
        adcWord = 16'hA5C3;
        auto_en = 1'b1;
        e0 = cyc;
        while (cyc < e0 + 199) @(negedge clk);
        start   = 1'b1;
        ex.data = 16'hA5C3;
        ex.cyc  = e0 + 200 + 137;
        sbQueue.push_back(ex);
        @(posedge clk);
        #1;
        checkOutput("coincide busy", {31'd0, busy}, 1);
        checkOutput("coincide overrun", {31'd0, overrun}, 0);
        @(negedge clk);
        start   = 1'b0;
        auto_en = 1'b0;
        waitIdle(400);
        repeat (250) @(negedge clk);
        checkOutput("coincide sb drained", sbQueue.size(), 0);
        checkOutput("coincide data", {16'd0, adc_data}, 32'hA5C3);
        checkOutput("coincide overrun end", {31'd0, overrun}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
